urp_pcie_crc32_stream_enc: RTL and testbench

URP_PCIE_CRC32_STREAM_ENC -- requirements
Module: URP_PCIE_CRC32_STREAM_ENC

---
 rtl/urp_pcie_crc32_stream_enc_if.sv | 33 +++
 rtl/urp_pcie_crc32_stream_enc.sv | 131 +++++++++++++
 tb/tb_urp_pcie_crc32_stream_enc.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/urp_pcie_crc32_stream_enc_if.sv
`timescale 1ns/1ps
// Beat stream bundle for the CRC-32 stream encoder: upstream side (valid_i/ready_o)
// and downstream side (valid_o/ready_i) with the per-packet checksum and beat count.
interface urp_pcie_crc32_stream_enc_if #(
  parameter int DATA_WIDTH = 512,
  parameter int CRC_WIDTH  = 32,
  parameter int CNT_WIDTH  = 16
) ();
  logic                  valid_i;
  logic                  ready_o;
  logic                  sop_i;
  logic                  eop_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  valid_o;
  logic                  ready_i;
  logic                  sop_o;
  logic                  eop_o;
  logic [DATA_WIDTH-1:0] data_o;
  logic [CRC_WIDTH-1:0]  checksum_o;
  logic [CNT_WIDTH-1:0]  beat_cnt_o;

  // Encoder side.
  modport slave (
    input  valid_i, sop_i, eop_i, data_i, ready_i,
    output ready_o, valid_o, sop_o, eop_o, data_o, checksum_o, beat_cnt_o
  );

  // Source/sink side driving the encoder.
  modport master (
    output valid_i, sop_i, eop_i, data_i, ready_i,
    input  ready_o, valid_o, sop_o, eop_o, data_o, checksum_o, beat_cnt_o
  );
endinterface

// File: rtl/urp_pcie_crc32_stream_enc.sv
`timescale 1ns/1ps
// CRC-32/BZIP2 stream encoder, one registered stage (latency 1); ready_o = !valid_o || ready_i,
// outputs hold while stalled. Macro URP_PCIE_CRC_PROTO_CHK_EN adds sticky proto_err_o.
module urp_pcie_crc32_stream_enc #(
  parameter int                   DATA_WIDTH = 512,
  parameter int                   CRC_WIDTH  = 32,
  parameter logic [CRC_WIDTH-1:0] POLY       = 32'h04C11DB7,
  parameter int                   CNT_WIDTH  = 16
) (
  input logic                        clk,
  input logic                        rst_n,
  urp_pcie_crc32_stream_enc_if.slave bus
`ifdef URP_PCIE_CRC_PROTO_CHK_EN
  ,
  output logic                       proto_err_o
`endif
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [CRC_WIDTH-1:0] CRC_INIT = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_t                state_q, state_nx;
  logic [CRC_WIDTH-1:0]  crc_q, crc_nx, crc_seed, crc_upd;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_nx;
  logic                  accept;

  logic                  valid_q, sop_q, eop_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CRC_WIDTH-1:0]  cks_q;
  logic [CNT_WIDTH-1:0]  bcnt_q;

  // Whole beat folded in one cycle, MSB first; unrolls to a pure XOR network.
  function automatic logic [CRC_WIDTH-1:0] crc_step(input logic [CRC_WIDTH-1:0]  crc_in,
                                                    input logic [DATA_WIDTH-1:0] dat);
    logic [CRC_WIDTH-1:0] c;
    logic                 fb;
    c = crc_in;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      fb = c[CRC_WIDTH-1] ^ dat[i];
      c  = {c[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    return c;
  endfunction

  assign bus.ready_o = !valid_q || bus.ready_i;
  assign accept      = bus.valid_i && bus.ready_o;

  // A sop beat always reseeds, so one update network serves both start and continuation.
  assign crc_seed = bus.sop_i ? CRC_INIT : crc_q;
  assign crc_upd  = crc_step(crc_seed, bus.data_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      crc_q   <= CRC_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nx;
      crc_q   <= crc_nx;
      cnt_q   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    crc_nx   = crc_q;
    cnt_nx   = cnt_q;
    if (accept) begin
      if (bus.sop_i) begin
        crc_nx   = crc_upd;
        cnt_nx   = CNT_ONE;
        state_nx = bus.eop_i ? IDLE : ACCUM;
      end else if (state_q == ACCUM) begin
        crc_nx = crc_upd;
        cnt_nx = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        if (bus.eop_i) begin
          state_nx = IDLE;
        end
      end
    end
  end

  // Stray beats in IDLE still pass through; their checksum/count fields carry no meaning.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      data_q  <= '0;
      cks_q   <= '0;
      bcnt_q  <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      sop_q   <= bus.sop_i;
      eop_q   <= bus.eop_i;
      data_q  <= bus.data_i;
      cks_q   <= ~crc_nx;
      bcnt_q  <= cnt_nx;
    end else if (bus.ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.valid_o    = valid_q;
  assign bus.sop_o      = sop_q;
  assign bus.eop_o      = eop_q;
  assign bus.data_o     = data_q;
  assign bus.checksum_o = cks_q;
  assign bus.beat_cnt_o = bcnt_q;

`ifdef URP_PCIE_CRC_PROTO_CHK_EN
  logic proto_evt;
  logic proto_err_q;

  assign proto_evt = accept && ((state_q == ACCUM) ? bus.sop_i : !bus.sop_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proto_err_q <= 1'b0;
    end else if (proto_evt) begin
      proto_err_q <= 1'b1;
    end
  end

  assign proto_err_o = proto_err_q;
`endif

endmodule

// File: tb/tb_urp_pcie_crc32_stream_enc.sv
`timescale 1ns/1ps
// Bench for urp_pcie_crc32_stream_enc: scoreboard against a byte-level CRC-32/BZIP2 model
// plus literal checks on the "123456789" vector at several widths.
module tb_urp_pcie_crc32_stream_enc;

  localparam logic [31:0] CHECK_CRC = 32'hFC891918;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic        sop;
    logic        eop;
    logic [7:0]  dat;
    logic [31:0] cks;
    int          cnt;
    bit          meaningful;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int rdy_mode = 0;  // 0: ready, 1: random, 2: stalled

  urp_pcie_crc32_stream_enc_if #(.DATA_WIDTH(8),  .CRC_WIDTH(32), .CNT_WIDTH(16)) if0 ();
  urp_pcie_crc32_stream_enc_if #(.DATA_WIDTH(72), .CRC_WIDTH(32), .CNT_WIDTH(16)) if1 ();
  urp_pcie_crc32_stream_enc_if #(.DATA_WIDTH(8),  .CRC_WIDTH(32), .CNT_WIDTH(2))  if2 ();

`ifdef URP_PCIE_CRC_PROTO_CHK_EN
  logic perr0, perr1, perr2;
`endif

  urp_pcie_crc32_stream_enc #(.DATA_WIDTH(8), .CRC_WIDTH(32), .POLY(32'h04C11DB7), .CNT_WIDTH(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0)
`ifdef URP_PCIE_CRC_PROTO_CHK_EN
    , .proto_err_o(perr0)
`endif
  );
  urp_pcie_crc32_stream_enc #(.DATA_WIDTH(72), .CRC_WIDTH(32), .POLY(32'h04C11DB7), .CNT_WIDTH(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
`ifdef URP_PCIE_CRC_PROTO_CHK_EN
    , .proto_err_o(perr1)
`endif
  );
  urp_pcie_crc32_stream_enc #(.DATA_WIDTH(8), .CRC_WIDTH(32), .POLY(32'h04C11DB7), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2)
`ifdef URP_PCIE_CRC_PROTO_CHK_EN
    , .proto_err_o(perr2)
`endif
  );

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference CRC-32/BZIP2 over a byte sequence, byte-at-a-time into the top of the register.
  function automatic logic [31:0] ref_crc(input bq_t b);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (b[i]) begin
      c = c ^ {b[i], 24'h0};
      for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
    end
    return ~c;
  endfunction

  // Model state for dut0
  exp_t        exp_q[$];
  bq_t         pkt_bytes;
  bit          in_pkt = 0;
  int          pkt_cnt = 0;
  logic [31:0] last_cks;
  int          last_cnt;
  bit          stall_prev = 0;
  logic        p_sop, p_eop;
  logic [7:0]  p_dat;
  logic [31:0] p_cks;
  logic [15:0] p_cnt;
  exp_t        e_cur, e_new;

  always begin
    if0.ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       if0.ready_i = 1'b1;
        1:       if0.ready_i = ($urandom_range(0, 3) != 0);
        default: if0.ready_i = 1'b0;
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("valid_o", if0.valid_o, exp_q.size() != 0);
      chk("ready_o", if0.ready_o, !if0.valid_o || if0.ready_i);
      if (stall_prev) begin
        chk("hold_sop",  if0.sop_o,      p_sop);
        chk("hold_eop",  if0.eop_o,      p_eop);
        chk("hold_data", if0.data_o,     p_dat);
        chk("hold_cks",  if0.checksum_o, p_cks);
        chk("hold_cnt",  if0.beat_cnt_o, p_cnt);
      end
      if (if0.valid_o && exp_q.size() != 0) begin
        e_cur = exp_q[0];
        chk("out_sop",  if0.sop_o,  e_cur.sop);
        chk("out_eop",  if0.eop_o,  e_cur.eop);
        chk("out_data", if0.data_o, e_cur.dat);
        if (e_cur.eop && e_cur.meaningful) begin
          chk("out_cks", if0.checksum_o, e_cur.cks);
          chk("out_cnt", if0.beat_cnt_o, e_cur.cnt);
        end
        if (if0.ready_i) begin
          void'(exp_q.pop_front());
          if (e_cur.eop && e_cur.meaningful) begin
            last_cks = if0.checksum_o;
            last_cnt = int'(if0.beat_cnt_o);
          end
        end
      end
      stall_prev = if0.valid_o && !if0.ready_i;
      p_sop = if0.sop_o; p_eop = if0.eop_o; p_dat = if0.data_o;
      p_cks = if0.checksum_o; p_cnt = if0.beat_cnt_o;
      if (if0.valid_i && if0.ready_o) begin
        e_new.sop = if0.sop_i; e_new.eop = if0.eop_i; e_new.dat = if0.data_i;
        e_new.meaningful = 1'b1;
        if (if0.sop_i) begin
          pkt_bytes.delete();
          pkt_bytes.push_back(if0.data_i);
          pkt_cnt = 1;
          in_pkt  = !if0.eop_i;
        end else if (in_pkt) begin
          pkt_bytes.push_back(if0.data_i);
          pkt_cnt = (pkt_cnt < 65535) ? pkt_cnt + 1 : 65535;
          if (if0.eop_i) in_pkt = 0;
        end else begin
          e_new.meaningful = 1'b0;
        end
        e_new.cks = ref_crc(pkt_bytes);
        e_new.cnt = pkt_cnt;
        exp_q.push_back(e_new);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    if0.valid_i = 1'b0; if1.valid_i = 1'b0; if2.valid_i = 1'b0;
    exp_q.delete(); pkt_bytes.delete(); in_pkt = 0; pkt_cnt = 0; stall_prev = 0;
    @(negedge clk);
    chk("rst_valid_o", if0.valid_o, 0);
    chk("rst_sop_o",   if0.sop_o, 0);
    chk("rst_eop_o",   if0.eop_o, 0);
    chk("rst_data_o",  if0.data_o, 0);
    chk("rst_cks_o",   if0.checksum_o, 0);
    chk("rst_cnt_o",   if0.beat_cnt_o, 0);
    chk("rst_valid1",  if1.valid_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic send0(input logic s, input logic e, input logic [7:0] d);
    int n;
    n = 0;
    if0.valid_i = 1'b1; if0.sop_i = s; if0.eop_i = e; if0.data_i = d;
    @(negedge clk);
    while (!if0.ready_o && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL send0_timeout: ready_o=0 for 200 cycles, required 1");
    end
    @(posedge clk); #1;
    if0.valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || if0.valid_o) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL drain_timeout: output queue still holds %0d beats, required 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic send_str(input int first, input int last, input bit with_sop);
    string s;
    s = "123456789";
    for (int i = first; i <= last; i++) send0(with_sop && (i == first), i == 8, s[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t         b;
    logic [71:0] d72;
    string       s6;
    int          len, err, gap;
    logic        sop, eop;

    if0.valid_i = 0; if0.sop_i = 0; if0.eop_i = 0; if0.data_i = '0;
    if1.valid_i = 0; if1.sop_i = 0; if1.eop_i = 0; if1.data_i = '0; if1.ready_i = 1;
    if2.valid_i = 0; if2.sop_i = 0; if2.eop_i = 0; if2.data_i = '0; if2.ready_i = 1;
    do_reset();

    // Nine byte beats of "123456789"
    last_cks = '0; last_cnt = 0;
    send_str(0, 8, 1);
    drain();
    chk("bytes_cks", last_cks, CHECK_CRC);
    chk("bytes_cnt", last_cnt, 9);

    // Reset after beat 4, then the whole packet again
    send_str(0, 3, 1);
    do_reset();
    last_cks = '0; last_cnt = 0;
    send_str(0, 8, 1);
    drain();
    chk("rst_mid_cks", last_cks, CHECK_CRC);
    chk("rst_mid_cnt", last_cnt, 9);

    // Five stalled cycles with a beat waiting upstream
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    last_cks = '0; last_cnt = 0;
    send0(1, 0, "1");
    fork
      send_str(1, 8, 0);
      begin
        repeat (5) begin
          @(negedge clk);
          chk("stall_ready_o", if0.ready_o, 0);
          chk("stall_valid_o", if0.valid_o, 1);
        end
        rdy_mode = 0;
      end
    join
    drain();
    chk("stall_cks", last_cks, CHECK_CRC);
    chk("stall_cnt", last_cnt, 9);

    // 72-bit beat: whole string in one sop=eop beat
    if1.valid_i = 1; if1.sop_i = 1; if1.eop_i = 1; if1.data_i = 72'h31_32_33_34_35_36_37_38_39;
    @(posedge clk); #1;
    if1.valid_i = 0;
    @(negedge clk);
    chk("w72_valid", if1.valid_o, 1);
    chk("w72_data",  if1.data_o, 72'h31_32_33_34_35_36_37_38_39);
    chk("w72_cks",   if1.checksum_o, CHECK_CRC);
    chk("w72_cnt",   if1.beat_cnt_o, 1);
    @(posedge clk); #1;

    // 72-bit random three-beat packet
    b.delete();
    for (int i = 0; i < 3; i++) begin
      d72 = {$urandom(), $urandom(), 8'($urandom())};
      for (int k = 8; k >= 0; k--) b.push_back(d72[k*8 +: 8]);
      if1.valid_i = 1; if1.sop_i = (i == 0); if1.eop_i = (i == 2); if1.data_i = d72;
      @(posedge clk); #1;
    end
    if1.valid_i = 0;
    @(negedge clk);
    chk("w72r_eop", if1.eop_o, 1);
    chk("w72r_cks", if1.checksum_o, ref_crc(b));
    chk("w72r_cnt", if1.beat_cnt_o, 3);
    @(posedge clk); #1;

    // Two-bit counter saturates on a six-beat packet
    s6 = "ABCDEF";
    b.delete();
    for (int i = 0; i < 6; i++) begin
      b.push_back(s6[i]);
      if2.valid_i = 1; if2.sop_i = (i == 0); if2.eop_i = (i == 5); if2.data_i = s6[i];
      @(posedge clk); #1;
    end
    if2.valid_i = 0;
    @(negedge clk);
    chk("sat_cnt", if2.beat_cnt_o, 3);
    chk("sat_cks", if2.checksum_o, ref_crc(b));
    @(posedge clk); #1;

    // Random packets with random backpressure and occasional framing errors
    rdy_mode = 1;
    for (int p = 0; p < 80; p++) begin
      len = $urandom_range(1, 8);
      err = $urandom_range(0, 9);
      for (int i = 0; i < len; i++) begin
        sop = (i == 0);
        eop = (i == len - 1);
        if (err == 0 && i == 0 && len > 1) sop = 0;
        if (err == 1 && i == len / 2 && len > 2) sop = 1;
        send0(sop, eop, 8'($urandom()));
      end
      gap = $urandom_range(0, 2);
      repeat (gap) @(posedge clk);
      if (gap != 0) #1;
    end
    drain();
    rdy_mode = 0;

`ifdef URP_PCIE_CRC_PROTO_CHK_EN
    do_reset();
    chk("perr_reset", perr0, 0);
    send0(1, 0, "1");
    send0(0, 0, "2");
    chk("perr_clean", perr0, 0);
    last_cks = '0; last_cnt = 0;
    send0(1, 0, "1");
    @(negedge clk);
    chk("perr_set", perr0, 1);
    @(posedge clk); #1;
    send_str(1, 8, 0);
    drain();
    chk("perr_restart_cks", last_cks, CHECK_CRC);
    chk("perr_restart_cnt", last_cnt, 9);
    chk("perr_sticky", perr0, 1);
    do_reset();
    chk("perr_cleared", perr0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
